// File: rtl/sprite_arbiter_pkg.sv
// Shared types and helpers for the sprite-overlay arbiter: stream count,
// the "no sprite" code, the collision IRQ FSM states and the opacity rule.
package sprite_arbiter_pkg;

  localparam int         SPR_COUNT = 8;
  localparam logic [3:0] SPR_NONE  = 4'b0000;

  typedef enum logic {
    IRQ_ARMED = 1'b0,
    IRQ_FIRED = 1'b1
  } irq_state_e;

  // Multicolor sprites are transparent only on 2'b00; hires sprites use bit[1].
  function automatic logic spr_opaque(input logic [1:0] px, input logic mmc);
    return mmc ? (px != 2'b00) : px[1];
  endfunction

endpackage

// File: rtl/sprite_arbiter_coll.sv
// Read-to-clear sticky collision register with a one-strobe IRQ FSM that
// re-arms on every CPU read of the register.
module sprite_arbiter_coll
  import sprite_arbiter_pkg::*;
(
  input  logic                 clk_dot4x,
  input  logic                 rst_n,
  input  logic [SPR_COUNT-1:0] hit,
  input  logic                 rd,
  output logic [SPR_COUNT-1:0] bits,
  output logic                 irq
);

  logic [SPR_COUNT-1:0] bits_next;
  irq_state_e           state, state_next;

  // A hit arriving with the read survives the clear.
  assign bits_next = (rd ? '0 : bits) | hit;

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      bits  <= '0;
      state <= IRQ_ARMED;
    end else begin
      bits  <= bits_next;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IRQ_ARMED: if (rd) state_next = IRQ_ARMED;
                 else if (bits != '0) state_next = IRQ_FIRED;
      IRQ_FIRED: if (rd) state_next = IRQ_ARMED;
      default:   state_next = IRQ_ARMED;
    endcase
  end

  // The strobe lasts the single clk spent ARMED with a nonzero register.
  always_comb begin
    irq = (state == IRQ_ARMED) && (bits != '0);
  end

endmodule

// File: rtl/sprite_arbiter_prio.sv
// Combinational priority encoder: lowest-index opaque sprite wins, plus a
// flag telling whether two or more sprites are opaque at once.
module sprite_arbiter_prio
  import sprite_arbiter_pkg::*;
(
  input  logic [SPR_COUNT-1:0] opq,
  output logic [3:0]           win,
  output logic                 multi
);

  always_comb begin
    // NOTE: default first so every path assigns win and no latch is inferred.
    win = SPR_NONE;
    for (int i = SPR_COUNT - 1; i >= 0; i--) begin
      if (opq[i]) win = {1'b1, 3'(i)};
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = (opq & (opq - 8'd1)) != '0;

endmodule

// File: rtl/sprite_arbiter.sv
// Per-pixel arbiter for the 8 sprite streams: picks the winning sprite for
// the pixel sequencer and latches sprite-sprite / sprite-data collisions.
module sprite_arbiter
  import sprite_arbiter_pkg::*;
#(
  parameter int NUM_SPRITES   = SPR_COUNT,
  parameter bit M2D_IN_BORDER = 1'b0
) (
  input  logic                     clk_dot4x,
  input  logic                     rst_n,
  input  logic                     pixel_tick,
  input  logic [2*NUM_SPRITES-1:0] sprite_cur_pixel_o,
  input  logic [NUM_SPRITES-1:0]   sprite_mmc_d,
  input  logic                     fg_pixel,
  input  logic                     main_border,
  input  logic                     rd_m2m,
  input  logic                     rd_m2d,
  output logic [3:0]               active_sprite_d,
  output logic [NUM_SPRITES-1:0]   m2m,
  output logic [NUM_SPRITES-1:0]   m2d,
  output logic                     irq_m2m,
  output logic                     irq_m2d
);

  logic [NUM_SPRITES-1:0]      opq;
  logic [3:0]                  win;
  logic                        multi;
  logic [1:0][NUM_SPRITES-1:0] hit_v, bits_v;
  logic [1:0]                  rd_v, irq_v;

  // Sprite 0 occupies the top bit pair of the pixel bus.
  always_comb begin
    for (int n = 0; n < NUM_SPRITES; n++) begin
      opq[n] = spr_opaque(sprite_cur_pixel_o[2*NUM_SPRITES-1-2*n -: 2], sprite_mmc_d[n]);
    end
  end

  sprite_arbiter_prio u_prio (
    .opq   (opq),
    .win   (win),
    .multi (multi)
  );

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n)          active_sprite_d <= SPR_NONE;
    else if (pixel_tick) active_sprite_d <= win;
  end

  assign hit_v[0] = (pixel_tick && multi) ? opq : '0;
  assign hit_v[1] = (pixel_tick && fg_pixel && (M2D_IN_BORDER || !main_border)) ? opq : '0;
  assign rd_v     = {rd_m2d, rd_m2m};

  for (genvar g = 0; g < 2; g++) begin : g_coll
    sprite_arbiter_coll u_coll (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .hit       (hit_v[g]),
      .rd        (rd_v[g]),
      .bits      (bits_v[g]),
      .irq       (irq_v[g])
    );
  end

  assign m2m     = bits_v[0];
  assign m2d     = bits_v[1];
  assign irq_m2m = irq_v[0];
  assign irq_m2d = irq_v[1];

endmodule

// File: tb/tb_sprite_arbiter.sv
// Self-checking bench for sprite_arbiter: directed scenarios followed by
// randomized pixels checked against a per-pixel behavioural model.
module tb_sprite_arbiter;

  localparam bit TB_M2D_IN_BORDER = 1'b0;

  logic        clk_dot4x = 1'b0;
  logic        rst_n;
  logic        pixel_tick;
  logic [15:0] sprite_cur_pixel_o;
  logic [7:0]  sprite_mmc_d;
  logic        fg_pixel, main_border, rd_m2m, rd_m2d;
  logic [3:0]  active_sprite_d;
  logic [7:0]  m2m, m2d;
  logic        irq_m2m, irq_m2d;

  int tot = 0;
  int bad = 0;

  logic [3:0] exp_act;
  logic [7:0] exp_m2m, exp_m2d;
  logic       exp_irq_mm, exp_irq_md;

  sprite_arbiter #(
    .NUM_SPRITES   (8),
    .M2D_IN_BORDER (TB_M2D_IN_BORDER)
  ) dut (
    .clk_dot4x          (clk_dot4x),
    .rst_n              (rst_n),
    .pixel_tick         (pixel_tick),
    .sprite_cur_pixel_o (sprite_cur_pixel_o),
    .sprite_mmc_d       (sprite_mmc_d),
    .fg_pixel           (fg_pixel),
    .main_border        (main_border),
    .rd_m2m             (rd_m2m),
    .rd_m2d             (rd_m2d),
    .active_sprite_d    (active_sprite_d),
    .m2m                (m2m),
    .m2d                (m2d),
    .irq_m2m            (irq_m2m),
    .irq_m2d            (irq_m2d)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] px_of(input int n, input logic [1:0] v);
    logic [15:0] w;
    w = {14'd0, v};
    return w << (14 - 2 * n);
  endfunction

  // Opacity straight from the pixel definition: multicolor = any nonzero
  // value, hires = pixel value 2 or 3.
  function automatic logic [7:0] model_opq(input logic [15:0] px, input logic [7:0] mmc);
    logic [7:0] o;
    int p;
    for (int n = 0; n < 8; n++) begin
      p = int'((px >> (14 - 2 * n)) & 16'd3);
      o[n] = mmc[n] ? (p != 0) : (p >= 2);
    end
    return o;
  endfunction

  task automatic model_reset();
    exp_act = 4'd0; exp_m2m = 8'd0; exp_m2d = 8'd0;
    exp_irq_mm = 1'b0; exp_irq_md = 1'b0;
  endtask

  task automatic check_all();
    check("act", {12'd0, active_sprite_d}, {12'd0, exp_act});
    check("m2m", {8'd0, m2m}, {8'd0, exp_m2m});
    check("m2d", {8'd0, m2d}, {8'd0, exp_m2d});
    check("irq_m2m", {15'd0, irq_m2m}, {15'd0, exp_irq_mm});
    check("irq_m2d", {15'd0, irq_m2d}, {15'd0, exp_irq_md});
  endtask

  // One clk: drive inputs, advance the model by the pixel rules, compare.
  task automatic step(input logic [15:0] px, input logic [7:0] mmc, input logic tick,
                      input logic fg, input logic border, input logic rmm, input logic rmd);
    logic [7:0] opq, mmh, mdh, nm, nd;
    int cnt, first;
    sprite_cur_pixel_o = px; sprite_mmc_d = mmc; pixel_tick = tick;
    fg_pixel = fg; main_border = border; rd_m2m = rmm; rd_m2d = rmd;
    opq = model_opq(px, mmc);
    cnt = 0; first = -1;
    for (int n = 0; n < 8; n++) begin
      if (opq[n]) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    mmh = 8'd0; mdh = 8'd0;
    if (tick) begin
      exp_act = (first < 0) ? 4'd0 : {1'b1, 3'(first)};
      if (cnt >= 2) mmh = opq;
      if (fg && (TB_M2D_IN_BORDER || !border)) mdh = opq;
    end
    nm = (rmm ? 8'd0 : exp_m2m) | mmh;
    nd = (rmd ? 8'd0 : exp_m2d) | mdh;
    // A strobe follows any edge that leaves the register nonzero after it was
    // empty or after a read re-armed it.
    exp_irq_mm = (nm != 0) && (exp_m2m == 0 || rmm);
    exp_irq_md = (nd != 0) && (exp_m2d == 0 || rmd);
    exp_m2m = nm; exp_m2d = nd;
    @(posedge clk_dot4x); #1;
    check_all();
  endtask

  task automatic idle();
    step(16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    sprite_cur_pixel_o = 16'd0; sprite_mmc_d = 8'd0; pixel_tick = 1'b0;
    fg_pixel = 1'b0; main_border = 1'b0; rd_m2m = 1'b0; rd_m2d = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk_dot4x); rst_n = 1'b1;
    @(posedge clk_dot4x); #1;
    check_all();
    step(16'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Priority: hires sprite 3 and multicolor sprite 5.
    step(px_of(3, 2'b10) | px_of(5, 2'b01), 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_act", {12'd0, active_sprite_d}, 16'h000b);
    check("t2_m2m", {8'd0, m2m}, 16'h0028);
    check("t2_irq", {15'd0, irq_m2m}, 16'h0001);
    idle();
    check("t2_irq_once", {15'd0, irq_m2m}, 16'h0000);

    // Transparency: hires sprite with pixel 2'b01.
    step(px_of(2, 2'b01), 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_act", {12'd0, active_sprite_d}, 16'h0000);

    // Sprite-data collision gated off inside the main border.
    step(px_of(0, 2'b10), 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_border", {8'd0, m2d}, 16'h0000);
    step(px_of(0, 2'b10), 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_m2d", {8'd0, m2d}, 16'h0001);
    check("t4_irq", {15'd0, irq_m2d}, 16'h0001);
    idle();

    // Sticky accumulation with no re-fire, then read and re-fire.
    step(px_of(6, 2'b11) | px_of(7, 2'b10), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_m2m", {8'd0, m2m}, 16'h00e8);
    check("t5_noirq", {15'd0, irq_m2m}, 16'h0000);
    step(16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_clr", {8'd0, m2m}, 16'h0000);
    step(px_of(1, 2'b10) | px_of(2, 2'b11), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_refire", {15'd0, irq_m2m}, 16'h0001);
    idle();

    // Read and sprite-data hit in the same clk.
    step(px_of(4, 2'b10), 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_m2d", {8'd0, m2d}, 16'h0010);
    check("t6_irq", {15'd0, irq_m2d}, 16'h0001);
    idle();
    step(16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        // Asynchronous reset applied mid-cycle, released on a falling edge.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        idle();
        @(negedge clk_dot4x); rst_n = 1'b1;
        @(posedge clk_dot4x); #1;
        check_all();
      end
      step(16'($urandom) & 16'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
